// File: rtl/clock_div_prog.sv
// Programmable integer-N clock divider: 50% duty for odd and even N, divisor
// changes applied only at output-period boundaries, run/stop gating and bypass.
module clock_div_prog #(
    parameter int SIZE      = 8,
    parameter int RESET_DIV = 2
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic [SIZE-1:0] N,
    input  logic            load,
    input  logic            enable,
    output logic            out,
    output logic            tick,
    output logic            busy,
    output logic [SIZE-1:0] div_cur
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_cnt;
    logic [SIZE-1:0] r_pend;
    logic            r_hi_p;
    logic            r_hi_n;
    logic            r_run_n;

    logic            w_bypass;
    logic            w_boundary;
    logic            w_apply;
    logic            w_hi_next;
    logic            w_out;
    logic [SIZE-1:0] w_last;
    logic [SIZE-1:0] w_half;
    logic [SIZE-1:0] w_cnt_inc;

    // Period decode derived from the divisor in effect.
    always_comb begin
        w_bypass   = (div_cur < SIZE'(2));
        w_last     = div_cur - SIZE'(1);
        w_half     = div_cur >> 1'b1;
        w_cnt_inc  = r_cnt + SIZE'(1);
        w_hi_next  = (w_cnt_inc < w_half);
        w_boundary = (r_state == RUN) && (w_bypass || (r_cnt == w_last));
        w_apply    = busy && ((r_state == STOP) || w_boundary);
    end

    // Run/stop control, period counter, load/busy handshake and rising-edge phase.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= STOP;
            r_cnt   <= {SIZE{1'b0}};
            r_pend  <= {SIZE{1'b0}};
            r_hi_p  <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            div_cur <= SIZE'(RESET_DIV);
        end else begin
            // A pending divisor wins over a new request on the same edge.
            if (w_apply) begin
                div_cur <= r_pend;
                busy    <= 1'b0;
            end else if (load && !busy) begin
                r_pend <= N;
                busy   <= 1'b1;
            end else begin
                busy <= busy;
            end

            case (r_state)
                STOP: begin
                    r_cnt <= {SIZE{1'b0}};
                    if (enable) begin
                        r_state <= RUN;
                        r_hi_p  <= 1'b1;
                        tick    <= 1'b1;
                    end else begin
                        r_hi_p <= 1'b0;
                        tick   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_boundary) begin
                        r_cnt <= {SIZE{1'b0}};
                        if (enable) begin
                            r_hi_p <= 1'b1;
                            tick   <= 1'b1;
                        end else begin
                            r_state <= STOP;
                            r_hi_p  <= 1'b0;
                            tick    <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_hi_p <= w_hi_next;
                        tick   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= STOP;
                    r_cnt   <= {SIZE{1'b0}};
                    r_hi_p  <= 1'b0;
                    tick    <= 1'b0;
                end
            endcase
        end
    end

    // Falling-edge stage: half-cycle extension for odd divisors and bypass gate.
    always_ff @(negedge clk or negedge resetb) begin
        if (!resetb) begin
            r_hi_n  <= 1'b0;
            r_run_n <= 1'b0;
        end else begin
            r_hi_n  <= r_hi_p;
            r_run_n <= (r_state == RUN);
        end
    end

    // Output select; mode only changes at a boundary while the output is low.
    always_comb begin
        if (w_bypass) begin
            w_out = clk & r_run_n;
        end else if (div_cur[0]) begin
            w_out = r_hi_p | r_hi_n;
        end else begin
            w_out = r_hi_p;
        end
    end

    assign out = w_out;

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog: expected output periods are queued by the
// stimulus and checked by a monitor that measures each period between ticks.
module tb_clock_div_prog;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            resetb;
    logic [SIZE-1:0] N;
    logic            load;
    logic            enable;
    logic            out;
    logic            tick;
    logic            busy;
    logic [SIZE-1:0] div_cur;

    typedef struct {
        int len;
        int highs;
        int div;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    int   m_len    = 0;
    int   m_highs  = 0;
    int   m_pulses = 0;
    int   m_div    = 0;
    bit   m_active = 1'b0;
    logic m_prev   = 1'b0;

    clock_div_prog #(.SIZE(SIZE), .RESET_DIV(2)) dut (
        .clk    (clk),
        .resetb (resetb),
        .N      (N),
        .load   (load),
        .enable (enable),
        .out    (out),
        .tick   (tick),
        .busy   (busy),
        .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic goto_edge(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            #2;
            edge_n++;
        end
    endtask

    task automatic push(input int len, input int highs, input int div, input int count);
        rec_t r;
        r.len   = len;
        r.highs = highs;
        r.div   = div;
        repeat (count) exp_q.push_back(r);
    endtask

    task automatic finalize_period();
        rec_t r;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_period @edge %0d: got len=%0d highs=%0d div=%0d, none expected",
                     edge_n, m_len, m_highs, m_div);
        end else begin
            r = exp_q.pop_front();
            if (m_len != r.len || m_highs != r.highs || m_pulses != 1 || m_div != r.div) begin
                n_fail++;
                $display("FAIL period @edge %0d: got len=%0d highs=%0d pulses=%0d div=%0d expected len=%0d highs=%0d pulses=1 div=%0d",
                         edge_n, m_len, m_highs, m_pulses, m_div, r.len, r.highs, r.div);
            end
        end
    endtask

    task automatic count_half();
        if (out === 1'b1) m_highs++;
        if (out === 1'b1 && m_prev !== 1'b1) m_pulses++;
        m_prev = out;
    endtask

    // Monitor: out is sampled once per half clock; highs counts half-cycles high.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resetb !== 1'b1) begin
                m_active = 1'b0;
                m_prev   = 1'b0;
            end else begin
                if (tick === 1'b1) begin
                    if (m_active) finalize_period();
                    m_active = 1'b1;
                    m_len    = 0;
                    m_highs  = 0;
                    m_pulses = 0;
                    m_div    = int'(div_cur);
                end
                if (m_active) begin
                    m_len++;
                    count_half();
                end else begin
                    m_prev = out;
                end
            end
            @(negedge clk);
            #1;
            if (resetb !== 1'b1) begin
                m_active = 1'b0;
                m_prev   = 1'b0;
            end else if (m_active) begin
                count_half();
            end else begin
                m_prev = out;
            end
        end
    end

    initial begin
        resetb = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        N      = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out", out, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_div", div_cur, 2);
        resetb = 1'b1;
        enable = 1'b1;

        // Divide by 2 straight out of reset, then load 5 at a period start.
        push(2, 2, 2, 2);
        goto_edge(1);
        chk("start_tick", tick, 1'b1);
        chk("start_out", out, 1'b1);
        goto_edge(2);
        chk("p2_low_tick", tick, 1'b0);
        chk("p2_low_out", out, 1'b0);
        goto_edge(3);
        load = 1'b1;
        N    = 8'd5;
        goto_edge(4);
        chk("load5_busy", busy, 1'b1);
        chk("load5_div_hold", div_cur, 2);
        load = 1'b0;
        goto_edge(5);
        chk("load5_busy_clr", busy, 1'b0);
        chk("load5_div", div_cur, 5);
        chk("load5_tick", tick, 1'b1);
        push(5, 5, 5, 1);

        // Bypass request, a second request while busy is ignored.
        load = 1'b1;
        N    = 8'd1;
        goto_edge(6);
        chk("load1_busy", busy, 1'b1);
        N = 8'd7;
        goto_edge(7);
        chk("load7_ignored_busy", busy, 1'b1);
        load = 1'b0;
        goto_edge(9);
        chk("load1_pending_div", div_cur, 5);
        goto_edge(10);
        chk("bypass_div", div_cur, 1);
        chk("bypass_busy", busy, 1'b0);
        chk("bypass_tick", tick, 1'b1);
        push(1, 1, 1, 4);
        goto_edge(12);
        load = 1'b1;
        N    = 8'd7;
        goto_edge(13);
        chk("load7_busy", busy, 1'b1);
        load = 1'b0;
        goto_edge(14);
        chk("div7", div_cur, 7);
        push(7, 7, 7, 1);

        // Divide by 6, then stop mid-period and restart.
        load = 1'b1;
        N    = 8'd6;
        goto_edge(15);
        load = 1'b0;
        goto_edge(21);
        chk("div6", div_cur, 6);
        push(6, 6, 6, 1);
        push(10, 6, 6, 1);
        goto_edge(29);
        enable = 1'b0;
        goto_edge(33);
        chk("stop_tick", tick, 1'b0);
        chk("stop_out", out, 1'b0);
        goto_edge(36);
        chk("stopped_tick", tick, 1'b0);
        chk("stopped_out", out, 1'b0);
        enable = 1'b1;
        goto_edge(37);
        chk("restart_tick", tick, 1'b1);
        chk("restart_out", out, 1'b1);
        push(6, 6, 6, 1);

        // Divide by 3, then an asynchronous reset inside the high phase.
        load = 1'b1;
        N    = 8'd3;
        goto_edge(38);
        load = 1'b0;
        push(3, 3, 3, 2);
        goto_edge(43);
        chk("div3", div_cur, 3);
        goto_edge(49);
        chk("p3_high_before_reset", out, 1'b1);
        resetb = 1'b0;
        #1;
        chk("async_reset_out", out, 1'b0);
        chk("async_reset_div", div_cur, 2);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_tick", tick, 1'b0);
        goto_edge(51);
        resetb = 1'b1;
        goto_edge(52);
        chk("post_reset_tick", tick, 1'b1);
        chk("post_reset_div", div_cur, 2);
        push(2, 2, 2, 1);

        // Divide by 4, then a load landing exactly on a boundary edge.
        load = 1'b1;
        N    = 8'd4;
        goto_edge(53);
        load = 1'b0;
        goto_edge(54);
        chk("div4", div_cur, 4);
        push(4, 4, 4, 3);
        goto_edge(61);
        load = 1'b1;
        N    = 8'd3;
        goto_edge(62);
        chk("bnd_load_tick", tick, 1'b1);
        chk("bnd_load_busy", busy, 1'b1);
        chk("bnd_load_div_hold", div_cur, 4);
        load = 1'b0;
        push(3, 3, 3, 2);
        goto_edge(66);
        chk("bnd_load_div", div_cur, 3);
        chk("bnd_load_busy_clr", busy, 1'b0);
        goto_edge(73);

        chk("periods_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Programmable integer-N clock divider with a 50% duty cycle for both odd and even divisors.
- Divisor updates use a load/busy handshake and take effect only at an output-period boundary, so the output never produces runt pulses or glitches.
- Adds a glitch-free run/stop enable, a divide-by-1 bypass and a per-period tick strobe in the clk domain.
- Sits between the master clock source and the core/peripheral clock trees, alongside the existing divider.

Parameters:
SIZE, 8, width of the divisor N and of the internal period counter.
RESET_DIV, 2, divisor in effect after reset; legal range 1..2^SIZE-1.

Ports:
clk  input  1  source clock.
resetb  input  1  asynchronous reset, active-low.
N  input  SIZE  requested divisor; 0 and 1 both mean bypass (divide-by-1).
load  input  1  request to adopt N; sampled on posedge clk.
enable  input  1  run/stop control; sampled on posedge clk.
out  output  1  divided clock.
tick  output  1  one-clk pulse marking the first source cycle of each output period.
busy  output  1  high while a captured divisor is waiting for the next boundary.
div_cur  output  SIZE  divisor currently in effect.

Behaviour:
- One clock and one asynchronous active-low reset. Flops use both edges of clk: posedge for counter/control, negedge for the odd half-cycle stage.
- Reset (async, takes effect immediately, including mid-period): out=0, tick=0, busy=0, div_cur=RESET_DIV, cnt=0, hi_p=0, hi_n=0, pend=0, state=STOP.
- Effective period: P = div_cur. If div_cur<2, bypass mode applies.
- Divided mode (P>=2):
  - cnt counts 0..P-1 and wraps.
  - hi_p is a posedge flop loaded with (cnt_next < P>>1).
  - hi_n is a negedge flop that samples hi_p.
  - Even P: out = hi_p. Odd P: out = hi_p | hi_n, so the high phase lasts P/2 source cycles.
- Bypass mode: out = clk & run_n, where run_n is a negedge flop copy of (state==RUN). Gating changes only while clk is low.
- States:
  - STOP: cnt=0, hi_p=0, out low. On a posedge with enable=1, go to RUN with cnt=0, hi_p=1 and tick=1 in that same cycle.
  - RUN: cnt advances every posedge. A boundary occurs when cnt==P-1, or every cycle in bypass.
    - At a boundary with enable=0: go to STOP, hi_p=0, and the output completes its low phase.
    - At a boundary with enable=1: cnt=0, hi_p=1, tick=1.
- tick is registered; it is high for exactly one clk at the start of each output period. In bypass it is high every cycle while in RUN.
- Handshake:
  - load=1 with busy=0: capture N into pend and set busy=1 on the next posedge.
  - load=1 while busy=1: ignored; pend is not overwritten.
  - Apply point: pend is copied to div_cur at the next boundary in RUN, or at the next posedge in STOP. busy clears in that same edge.
  - Apply latency: 1 to P source cycles.
  - If load and the boundary land on the same edge, the new N is captured but not applied; it is applied at the following boundary.
- Transitions between divided and bypass mode happen only at a boundary, where out is low. No pulse is shorter than min(old, new) half-period.
- div_cur updates only at the apply point. N is don't-care except when captured.
- Counter arithmetic is SIZE bits. P-1 and P>>1 are computed from div_cur, so there is no overflow for P up to 2^SIZE-1.

Test Plan:
1. Reset with RESET_DIV=2, enable=1 -> out toggles every posedge (period 2 clk, high 1); tick once per 2 clk; div_cur=2; busy=0.
2. load N=5 while running at P=2 -> busy=1 next cycle, then 0 at the boundary; afterwards out period is 5 clk with a 2.5 clk high phase (measured edge to edge); no pulse shorter than 1 clk.
3. load N=1, then load N=7 while busy -> bypass adopted (out follows clk, tick every cycle); N=7 is ignored; a later load N=7 gives period 7 with no glitch at the switch.
4. Drop enable mid-period at P=6 -> out finishes its current period, then stays low and tick stops; raising enable -> out goes high and tick=1 on the first posedge.
5. Assert resetb low mid-high-phase at P=3 -> out drops to 0 immediately; after release div_cur=RESET_DIV and operation restarts from STOP.
6. load asserted on the exact boundary edge at P=4 with N=3 -> one more 4-clk period runs, then a 3-clk period with a 1.5 clk high phase.
